frame_buffer_mem_ctrl: RTL and testbench

FRAME_BUFFER_MEM_CTRL -- requirements
Module: frame_buffer_mem_ctrl

---
 rtl/frame_buffer_mem_ctrl_pkg.sv | 18 +
 rtl/frame_buffer_mem_ctrl_arbiter.sv | 38 +++
 rtl/frame_buffer_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_frame_buffer_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_mem_ctrl_pkg.sv
// Shared defaults, grant encoding and frame-size helper for frame_buffer_mem_ctrl.
package frame_buffer_mem_ctrl_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefMemDepth  = 4096;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WR,
        GRANT_RD
    } grant_e;

    function automatic logic [31:0] frame_size(input logic [15:0] width, input logic [15:0] depth);
        return 32'(width) * 32'(depth);
    endfunction

endpackage

// File: rtl/frame_buffer_mem_ctrl_arbiter.sv
// fb_rr_arbiter: single-port write/read arbiter, round-robin only on contended cycles.
module fb_rr_arbiter
    import frame_buffer_mem_ctrl_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   wr_i,
    input  logic   rd_i,
    output grant_e grant_o
);

    // Set when the most recent contended cycle went to the read side.
    logic last_rd_q, last_rd_d;

    always_comb begin
        grant_o   = GRANT_NONE;
        last_rd_d = last_rd_q;
        if (rst_i) begin
            grant_o = GRANT_NONE;
        end else if (wr_i && rd_i) begin
            grant_o   = last_rd_q ? GRANT_WR : GRANT_RD;
            last_rd_d = !last_rd_q;
        end else if (wr_i) begin
            grant_o = GRANT_WR;
        end else if (rd_i) begin
            grant_o = GRANT_RD;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_rd_q <= 1'b1;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: rtl/frame_buffer_mem_ctrl.sv
// Frame-buffer word store: arbitrated single-port memory with range and frame-end flags.
// Optional FB_PARITY_EN adds a stored even-parity bit and a parity_err_o output.
module frame_buffer_mem_ctrl
    import frame_buffer_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned MEM_DEPTH  = DefMemDepth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           resolution_width_i,
    input  logic [15:0]           resolution_depth_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_wr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_rd_i,
    output logic                  wr_ack_o,
    output logic                  rd_ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  addr_err_o,
    output logic                  frame_wr_done_o,
    output logic                  frame_rd_done_o
`ifdef FB_PARITY_EN
    ,
    output logic                  parity_err_o
`endif
);

    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CmpW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
`ifdef FB_PARITY_EN
    localparam int unsigned WordW = DATA_WIDTH + 1;
`else
    localparam int unsigned WordW = DATA_WIDTH;
`endif

    grant_e grant;

    fb_rr_arbiter u_arbiter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (wr_i),
        .rd_i    (rd_i),
        .grant_o (grant)
    );

    assign wr_ack_o = (grant == GRANT_WR);
    assign rd_ack_o = (grant == GRANT_RD);

    logic [WordW-1:0] mem_q [MEM_DEPTH];
    logic             wr_in_range, rd_in_range;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    logic [WordW-1:0] wr_word, rd_word;

    assign wr_in_range = addr_wr_i < ADDR_WIDTH'(MEM_DEPTH);
    assign rd_in_range = addr_rd_i < ADDR_WIDTH'(MEM_DEPTH);
    assign wr_idx      = addr_wr_i[IdxW-1:0];
    assign rd_idx      = addr_rd_i[IdxW-1:0];
    assign rd_word     = mem_q[rd_idx];
`ifdef FB_PARITY_EN
    assign wr_word = {^wdata_i, wdata_i};
`else
    assign wr_word = wdata_i;
`endif

    // Contents intentionally survive reset; wr_ack_o is already low while rst_i is high.
    always_ff @(posedge clk_i) begin
        if (wr_ack_o && wr_in_range) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    logic [31:0]     size;
    logic [CmpW-1:0] last_addr;
    logic            wr_last, rd_last;

    assign size      = frame_size(resolution_width_i, resolution_depth_i);
    assign last_addr = CmpW'(size - 32'd1);
    assign wr_last   = (size != 32'd0) && (CmpW'(addr_wr_i) == last_addr);
    assign rd_last   = (size != 32'd0) && (CmpW'(addr_rd_i) == last_addr);

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q, addr_err_q, wr_done_q, rd_done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            rvalid_q   <= rd_ack_o;
            addr_err_q <= (wr_ack_o && !wr_in_range) || (rd_ack_o && !rd_in_range);
            wr_done_q  <= wr_ack_o && wr_last;
            rd_done_q  <= rd_ack_o && rd_last;
            if (rd_ack_o) begin
                rdata_q <= rd_in_range ? rd_word[DATA_WIDTH-1:0] : '0;
            end
        end
    end

    assign rdata_o         = rdata_q;
    assign rvalid_o        = rvalid_q;
    assign addr_err_o      = addr_err_q;
    assign frame_wr_done_o = wr_done_q;
    assign frame_rd_done_o = rd_done_q;

`ifdef FB_PARITY_EN
    logic parity_err_q;

    // Stored word carries even parity, so any odd XOR over it is a corruption.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_ack_o && rd_in_range && (^rd_word);
        end
    end

    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_frame_buffer_mem_ctrl.sv
// Self-checking bench for frame_buffer_mem_ctrl: behavioural model plus directed literal checks.
module tb_frame_buffer_mem_ctrl;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   res_w = '0, res_h = '0;
    logic          wr = 1'b0, rd = 1'b0;
    logic [AW-1:0] addr_wr = '0, addr_rd = '0;
    logic [DW-1:0] wdata = '0;
    logic          wr_ack, rd_ack, rvalid, addr_err, wr_done, rd_done;
    logic [DW-1:0] rdata;
`ifdef FB_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    frame_buffer_mem_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .resolution_width_i (res_w),
        .resolution_depth_i (res_h),
        .wr_i               (wr),
        .addr_wr_i          (addr_wr),
        .wdata_i            (wdata),
        .rd_i               (rd),
        .addr_rd_i          (addr_rd),
        .wr_ack_o           (wr_ack),
        .rd_ack_o           (rd_ack),
        .rdata_o            (rdata),
        .rvalid_o           (rvalid),
        .addr_err_o         (addr_err),
        .frame_wr_done_o    (wr_done),
        .frame_rd_done_o    (rd_done)
`ifdef FB_PARITY_EN
        ,
        .parity_err_o       (parity_err)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: memory contents, whose turn on contention, expected registered outputs.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_turn_wr;
    bit            m_flip7;
    bit            e_rvalid, e_err, e_wdone, e_rdone, e_perr, e_rdata_known;
    logic [DW-1:0] e_rdata;

    initial begin
        bit          ea, er;
        logic [31:0] size;
        m_turn_wr     = 1'b1;
        m_flip7       = 1'b0;
        e_rvalid      = 1'b0;
        e_err         = 1'b0;
        e_wdone       = 1'b0;
        e_rdone       = 1'b0;
        e_perr        = 1'b0;
        e_rdata       = '0;
        e_rdata_known = 1'b1;
        forever begin
            @(negedge clk);
            chk("rvalid", rvalid, e_rvalid);
            chk("addr_err", addr_err, e_err);
            chk("frame_wr_done", wr_done, e_wdone);
            chk("frame_rd_done", rd_done, e_rdone);
            if (e_rdata_known) chk("rdata", rdata, e_rdata);
`ifdef FB_PARITY_EN
            chk("parity_err", parity_err, e_perr);
`endif
            ea = !rst && wr && (!rd || m_turn_wr);
            er = !rst && rd && (!wr || !m_turn_wr);
            chk("wr_ack", wr_ack, ea);
            chk("rd_ack", rd_ack, er);
            @(posedge clk);
            if (rst) begin
                m_turn_wr     = 1'b1;
                e_rvalid      = 1'b0;
                e_err         = 1'b0;
                e_wdone       = 1'b0;
                e_rdone       = 1'b0;
                e_perr        = 1'b0;
                e_rdata       = '0;
                e_rdata_known = 1'b1;
            end else begin
                size = 32'(res_w) * 32'(res_h);
                if (wr && rd) m_turn_wr = er;
                e_rvalid = er;
                e_err    = (ea && addr_wr >= DEPTH) || (er && addr_rd >= DEPTH);
                e_wdone  = ea && size != 0 && addr_wr == size - 1;
                e_rdone  = er && size != 0 && addr_rd == size - 1;
                e_perr   = er && addr_rd == 7 && m_flip7;
                if (er) begin
                    if (addr_rd >= DEPTH) begin
                        e_rdata       = '0;
                        e_rdata_known = 1'b1;
                    end else begin
                        e_rdata       = m_mem[addr_rd];
                        e_rdata_known = m_known[addr_rd];
                    end
                end
                if (ea && addr_wr < DEPTH) begin
                    m_mem[addr_wr]   = wdata;
                    m_known[addr_wr] = 1'b1;
                    if (addr_wr == 7) m_flip7 = 1'b0;
                end
            end
        end
    end

    bit la_w, la_r;

    // Drive one cycle from posedge+1; returns at the next posedge+1 with its results visible.
    task automatic cyc(input bit w, input logic [31:0] wa, input logic [15:0] wd,
                       input bit r, input logic [31:0] ra);
        wr      = w;
        addr_wr = wa;
        wdata   = wd;
        rd      = r;
        addr_rd = ra;
        @(negedge clk);
        la_w = wr_ack;
        la_r = rd_ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        int         cnt, at, acks;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        // Write then read same address back-to-back.
        cyc(1, 5, 16'hABCD, 0, 0);
        chk("w5_ack", la_w, 1);
        cyc(0, 0, 0, 1, 5);
        chk("r5_ack", la_r, 1);
        chk("r5_rvalid", rvalid, 1);
        chk("r5_rdata", rdata, 16'hABCD);

        // Sustained contention alternates starting with write.
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 20, 16'h1111, 1, 5);
            pat = {pat[2:0], la_w};
            if (la_r) chk("contend_rvalid", rvalid, 1);
        end
        chk("contend_pattern", pat, 4'b1010);
        cyc(0, 0, 0, 0, 0);

        // Reset lands while a read is acked; writes under reset are blocked.
        cyc(1, 9, 16'h1111, 0, 0);
        wr      = 1'b0;
        rd      = 1'b1;
        addr_rd = 5;
        @(negedge clk);
        chk("pre_reset_rd_ack", rd_ack, 1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_drops_rvalid", rvalid, 0);
        wr      = 1'b1;
        addr_wr = 9;
        wdata   = 16'h2222;
        rd      = 1'b0;
        @(negedge clk);
        chk("reset_wr_ack", wr_ack, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        cyc(1, 21, 16'h3333, 1, 9);
        chk("post_reset_grant_wr", la_w, 1);
        cyc(0, 0, 0, 1, 9);
        chk("mem_kept_through_reset", rdata, 16'h1111);

        // 8x4 frame: done once, after address 31.
        res_w = 16'd8;
        res_h = 16'd4;
        cnt   = 0;
        at    = -1;
        acks  = 0;
        for (int a = 0; a < 32; a++) begin
            cyc(1, a, 16'h0100 + 16'(a), 0, 0);
            acks += int'(la_w);
            if (wr_done) begin
                cnt++;
                at = a;
            end
        end
        chk("frame_wr_acks", acks, 32);
        chk("frame_wr_done_count", cnt, 1);
        chk("frame_wr_done_at", at, 31);
        cyc(0, 0, 0, 1, 30);
        chk("rd30_no_done", rd_done, 0);
        cyc(0, 0, 0, 1, 31);
        chk("rd31_done", rd_done, 1);
        chk("rd31_data", rdata, 16'h011F);

        // Zero-size frame never signals done, even at the all-ones address.
        res_w = 16'd0;
        cyc(1, 32'hFFFF_FFFF, 16'h5555, 0, 0);
        chk("size0_no_done", wr_done, 0);
        chk("size0_oob_err", addr_err, 1);
        res_w = 16'd8;

        // Out-of-range accesses and the top in-range word.
        cyc(1, 904, 16'h0123, 0, 0);
        cyc(0, 0, 0, 1, 5000);
        chk("oob_rd_rvalid", rvalid, 1);
        chk("oob_rd_rdata", rdata, 0);
        chk("oob_rd_err", addr_err, 1);
        cyc(1, 5000, 16'hBEEF, 0, 0);
        chk("oob_wr_err", addr_err, 1);
        cyc(0, 0, 0, 1, 904);
        chk("oob_wr_dropped", rdata, 16'h0123);
        chk("inrange_no_err", addr_err, 0);
        cyc(1, 4095, 16'h7777, 0, 0);
        cyc(0, 0, 0, 1, 4095);
        chk("top_word", rdata, 16'h7777);
        cyc(0, 0, 0, 1, 4096);
        chk("depth_oob_err", addr_err, 1);

`ifdef FB_PARITY_EN
        cyc(1, 7, 16'h00F0, 0, 0);
        dut.mem_q[7][0] = ~dut.mem_q[7][0];
        m_mem[7]        = m_mem[7] ^ 16'h0001;
        m_flip7         = 1'b1;
        cyc(0, 0, 0, 1, 7);
        chk("parity_err_flip", parity_err, 1);
        chk("parity_err_rvalid", rvalid, 1);
`endif

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
